// File: rtl/design_48_result_buf.sv
// Result buffer behind the design_48 arithmetic stage. It is a first-word-fall-through FIFO
// with a valid/ready output, plus overrun tracking: a sticky overflow flag and a saturating drop counter.
module design_48_result_buf #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [W-1:0]               in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [CW-1:0]              drop_cnt,
    input  logic                       clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          out_valid_r;
    logic          overflow_r;
    logic [CW-1:0] drop_cnt_r;

    logic          pop_s;
    logic          full_s;
    logic          push_s;
    logic          drop_s;
    logic [LW-1:0] level_nxt_s;
    logic          overflow_nxt_s;
    logic [CW-1:0] drop_cnt_nxt_s;

    // Handshake decode, occupancy update and overrun bookkeeping.
    // Full is taken from the level count, so the pointers may simply wrap.
    always_comb begin
        pop_s          = out_valid_r & out_ready;
        full_s         = (level_r == LW'(DEPTH));
        push_s         = in_valid & (~full_s | pop_s);
        drop_s         = in_valid & full_s & ~pop_s;
        level_nxt_s    = level_r;
        overflow_nxt_s = overflow_r;
        drop_cnt_nxt_s = drop_cnt_r;

        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase

        // A drop in the same cycle as a clear restarts the count at one.
        if (drop_s) begin
            overflow_nxt_s = 1'b1;
            if (clr_ovf) begin
                drop_cnt_nxt_s = CW'(1);
            end else if (drop_cnt_r == {CW{1'b1}}) begin
                drop_cnt_nxt_s = drop_cnt_r;
            end else begin
                drop_cnt_nxt_s = drop_cnt_r + CW'(1);
            end
        end else if (clr_ovf) begin
            overflow_nxt_s = 1'b0;
            drop_cnt_nxt_s = {CW{1'b0}};
        end else begin
            overflow_nxt_s = overflow_r;
            drop_cnt_nxt_s = drop_cnt_r;
        end
    end

    // Control state: pointers, occupancy, output valid and overrun status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            level_r     <= {LW{1'b0}};
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            drop_cnt_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r     <= level_nxt_s;
            out_valid_r <= (level_nxt_s != {LW{1'b0}});
            overflow_r  <= overflow_nxt_s;
            drop_cnt_r  <= drop_cnt_nxt_s;
        end
    end

    // Storage array. It is not reset; its contents are only qualified by the level count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    assign out_data  = mem_r[rd_ptr_r];
    assign out_valid = out_valid_r;
    assign level     = level_r;
    assign overflow  = overflow_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: doc/design_48_result_buf.md
Name: design_48_result_buf

Overview:
- Downstream stage of the design_48 datapath. Consumes the per-cycle result stream (y qualified by valid) and buffers it in a small first-word-fall-through FIFO.
- Presents results to the consumer through a valid/ready handshake.
- Tracks overrun: sticky overflow flag plus a saturating drop counter.
- Decouples the fixed-timing arithmetic stage from a back-pressuring consumer (bus master or result DMA).

Parameters:
- W, 16, result data width; must equal design_48 W.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CW, 8, drop counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  result strobe from design_48 valid.
- in_data  input  W  result from design_48 y.
- out_valid  output  1  buffer holds at least one entry.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  W  oldest buffered entry.
- level  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- overflow  output  1  sticky: at least one result was dropped.
- drop_cnt  output  CW  dropped results, saturating.
- clr_ovf  input  1  synchronous clear of overflow and drop_cnt.

Behaviour:
- Reset is asynchronous, active-low; clock is clk. While rst_n=0: rd/wr pointers=0, level=0, out_valid=0, overflow=0, drop_cnt=0. out_data is don't-care (memory is not reset). Reset mid-stream discards all contents.
- pop = out_valid & out_ready. push_req = in_valid.
- push accepted = in_valid & (level<DEPTH | pop). When full, a simultaneous pop frees the slot and the push is accepted.
- Accepted push writes in_data at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap).
- pop advances rd_ptr modulo DEPTH.
- level next = level + accepted_push - pop.
- out_valid = (level != 0). Registered state only; no combinational in_valid->out_valid path.
- out_data = mem[rd_ptr], combinational from storage (FWFT). Valid whenever out_valid=1 and stable until popped.
- Latency: push in cycle N is visible (out_valid=1, out_data=value) from cycle N+1 when the buffer was empty. No empty-bypass.
- Empty buffer with out_ready=1: no pop, no state change.
- Drop: in_valid=1 & level==DEPTH & !pop.
  - Data is discarded and FIFO contents are unchanged.
  - overflow<=1.
  - drop_cnt<=drop_cnt+1, saturating at 2^CW-1.
- clr_ovf=1 (no drop that cycle): overflow<=0, drop_cnt<=0.
- clr_ovf and drop in the same cycle: the drop wins; overflow<=1, drop_cnt<=1.
- Data ordering is strictly FIFO; no reordering and no duplication.
- Pointer wrap is exercised every DEPTH pushes. Full/empty is decided from level, not from pointer equality.

Test Plan:
- Reset then idle: out_valid=0, level=0, overflow=0, drop_cnt=0; out_ready=1 while empty causes no change.
- Push 0x1111 with out_ready=0: next cycle out_valid=1, out_data=0x1111, level=1. Assert out_ready one cycle: level=0, out_valid=0.
- Stream 0x0001..0x000A continuously with out_ready=1: each value emerges one cycle after its push, in order. level stays <=1 and pointers wrap twice.
- out_ready=0, push 6 values 0xA0..0xA5 (DEPTH=4): level=4, overflow=1, drop_cnt=2. Draining yields exactly 0xA0..0xA3.
- Full buffer, in_valid=1 and out_ready=1 in the same cycle: pop returns the oldest entry, new value is accepted, level stays 4, drop_cnt unchanged.
- drop_cnt=2: clr_ovf alone gives overflow=0, drop_cnt=0. clr_ovf coincident with a drop gives overflow=1, drop_cnt=1.
- 300 drops with CW=8: drop_cnt saturates at 255.
- Assert rst_n with 3 entries buffered: immediately out_valid=0 and level=0. After release, the first new push emerges correctly.
